// File: rtl/regfile_scoreboard.sv
// 32-entry register file with two registered read ports, one write-back port and a per-register busy scoreboard.
// Optional macro RF_BYPASS_EN: same-cycle write-back forwarding to the read ports, with post-update busy reads.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_busy,
  output logic              rt_busy,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_addr,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_err
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic              wb_hit;
  logic              alloc_hit;
  logic [DATA_W-1:0] rs_data_nxt;
  logic [DATA_W-1:0] rt_data_nxt;
  logic              rs_busy_nxt;
  logic              rt_busy_nxt;

  assign wb_hit    = wb_en && (wb_addr != '0);
  assign alloc_hit = alloc_en && (alloc_addr != '0);

  // Clear first, then set, so a same-cycle alloc of the written index wins.
  always_comb begin
    busy_nxt = busy;
    if (wb_hit) busy_nxt[wb_addr] = 1'b0;
    if (alloc_hit) busy_nxt[alloc_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
`ifdef RF_BYPASS_EN
    rs_data_nxt = (wb_hit && (wb_addr == rs_addr)) ? wb_data : regs[rs_addr];
    rt_data_nxt = (wb_hit && (wb_addr == rt_addr)) ? wb_data : regs[rt_addr];
    rs_busy_nxt = busy_nxt[rs_addr];
    rt_busy_nxt = busy_nxt[rt_addr];
`else
    rs_data_nxt = regs[rs_addr];
    rt_data_nxt = regs[rt_addr];
    rs_busy_nxt = busy[rs_addr];
    rt_busy_nxt = busy[rt_addr];
`endif
  end

  // regs[0] is never written (wb_hit excludes index 0), so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_hit) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= '0;
      rs_data <= '0;
      rt_data <= '0;
      rs_busy <= 1'b0;
      rt_busy <= 1'b0;
      wb_err  <= 1'b0;
    end else begin
      busy    <= busy_nxt;
      rs_data <= rs_data_nxt;
      rt_data <= rt_data_nxt;
      rs_busy <= rs_busy_nxt;
      rt_busy <= rt_busy_nxt;
      if (wb_hit && !busy[wb_addr]) wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: the driver queues hand-computed read results, the monitor checks them one cycle later.
module tb_regfile_scoreboard;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] rs_addr = '0;
  logic [ADDR_W-1:0] rt_addr = '0;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              rs_busy;
  logic              rt_busy;
  logic              alloc_en = 1'b0;
  logic [ADDR_W-1:0] alloc_addr = '0;
  logic              wb_en = 1'b0;
  logic [ADDR_W-1:0] wb_addr = '0;
  logic [DATA_W-1:0] wb_data = '0;
  logic              wb_err;

  regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .rs_busy(rs_busy), .rt_busy(rt_busy),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic [DATA_W-1:0] rs_d;
    logic [DATA_W-1:0] rt_d;
    logic              rs_b;
    logic              rt_b;
    logic              err;
    int                due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    total++;
    if (act !== req) $display("FAIL %s actual=%h required=%h", nm, act, req);
    else passed++;
  endtask

  // Monitor: pops every expectation that falls due on this edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        check({e.name, "_due"}, DATA_W'(e.due), DATA_W'(cyc));
        check({e.name, "_rs_data"}, rs_data, e.rs_d);
        check({e.name, "_rt_data"}, rt_data, e.rt_d);
        check({e.name, "_rs_busy"}, DATA_W'(rs_busy), DATA_W'(e.rs_b));
        check({e.name, "_rt_busy"}, DATA_W'(rt_busy), DATA_W'(e.rt_b));
        check({e.name, "_wb_err"}, DATA_W'(wb_err), DATA_W'(e.err));
      end
    end
  end

  task automatic step(input logic ae, input logic [ADDR_W-1:0] aa,
                      input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                      input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt,
                      input bit chk, input string nm,
                      input logic [DATA_W-1:0] ers, input logic [DATA_W-1:0] ert,
                      input logic ebs, input logic ebt, input logic eerr);
    exp_t e;
    @(negedge clk);
    alloc_en = ae; alloc_addr = aa;
    wb_en = we; wb_addr = wa; wb_data = wd;
    rs_addr = rs; rt_addr = rt;
    if (chk) begin
      e.name = nm; e.rs_d = ers; e.rt_d = ert;
      e.rs_b = ebs; e.rt_b = ebt; e.err = eerr; e.due = cyc + 1;
      q.push_back(e);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, "", 0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Traffic so that outputs are non-zero before the mid-cycle reset.
    step(1, 7, 0, 0, 0, 0, 0, 0, "", 0, 0, 0, 0, 0);
    step(0, 0, 1, 7, 32'hDEADBEEF, 7, 7, 1, "pre_same_cycle",
         BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0, !BYP, !BYP, 0);
    step(0, 0, 0, 0, 0, 7, 7, 1, "pre_read", 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
    idle();

    // Asynchronous reset, sampled with no clock edge in between.
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_rs_data", rs_data, '0);
    check("async_rst_rt_data", rt_data, '0);
    check("async_rst_rs_busy", DATA_W'(rs_busy), '0);
    check("async_rst_rt_busy", DATA_W'(rt_busy), '0);
    check("async_rst_wb_err", DATA_W'(wb_err), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    step(0, 0, 0, 0, 0, 5, 7, 1, "post_rst_read", 0, 0, 0, 0, 0);

    // Write/read, and the dropped write to R0.
    step(1, 7, 0, 0, 0, 0, 0, 0, "", 0, 0, 0, 0, 0);
    step(0, 0, 1, 7, 32'hDEADBEEF, 0, 0, 0, "", 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 7, 7, 1, "rd_r7", 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
    step(0, 0, 1, 0, 32'h1234, 0, 0, 0, "", 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, "rd_r0", 0, 0, 0, 0, 0);

    // Scoreboard set and clear.
    step(1, 3, 0, 0, 0, 0, 0, 0, "", 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 3, 0, 1, "r3_busy", 0, 0, 1, 0, 0);
    step(0, 0, 1, 3, 32'h55, 0, 0, 0, "", 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 3, 7, 1, "r3_done", 32'h55, 32'hDEADBEEF, 0, 0, 0);

    // Alloc beats same-cycle write-back on the same index.
    step(1, 9, 0, 0, 0, 0, 0, 0, "", 0, 0, 0, 0, 0);
    step(1, 9, 1, 9, 32'hA, 0, 0, 0, "", 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 9, 9, 1, "r9_prio", 32'hA, 32'hA, 1, 1, 0);

    // R0 can never become busy.
    step(1, 0, 0, 0, 0, 0, 0, 0, "", 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 9, 1, "r0_alloc", 0, 32'hA, 0, 1, 0);

    // Same-cycle write-back and read of R4.
    step(1, 4, 0, 0, 0, 0, 0, 0, "", 0, 0, 0, 0, 0);
    step(0, 0, 1, 4, 32'h11, 0, 0, 0, "", 0, 0, 0, 0, 0);
    step(1, 4, 0, 0, 0, 0, 0, 0, "", 0, 0, 0, 0, 0);
    step(0, 0, 1, 4, 32'h77, 4, 9, 1, "r4_bypass",
         BYP ? 32'h77 : 32'h11, 32'hA, !BYP, 1, 0);
    step(0, 0, 0, 0, 0, 4, 4, 1, "r4_after", 32'h77, 32'h77, 0, 0, 0);

    // Write-back to a non-busy register sets the sticky error.
    step(0, 0, 1, 12, 32'h1, 0, 0, 1, "err_set", 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 12, 3, 1, "r12_read", 32'h1, 32'h55, 0, 0, 1);
    step(1, 20, 0, 0, 0, 0, 0, 0, "", 0, 0, 0, 0, 0);
    step(0, 0, 1, 20, 32'hFF, 20, 12, 1, "legal_wb",
         BYP ? 32'hFF : 32'h0, 32'h1, !BYP, 0, 1);
    step(0, 0, 0, 0, 0, 20, 12, 1, "err_sticky", 32'hFF, 32'h1, 0, 0, 1);
    idle();

    repeat (3) @(negedge clk);
    check("queue_drain", DATA_W'(q.size()), '0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
